// File: rtl/p2s_stream_scheduler.sv
// p2s_stream_scheduler: round-robin arbiter that snapshots one requester's word vector
// and streams it word by word over a valid/ready bus tagged with the requester id
module p2s_stream_scheduler #(
  parameter int N = 8,
  parameter int Length = 3,
  parameter int NumReq = 4,
  localparam int CW = $clog2(Length + 1),
  localparam int IW = $clog2(NumReq)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumReq-1:0]                   req_i,
  output logic [NumReq-1:0]                   gnt_o,
  input  logic [NumReq-1:0][Length-1:0][N-1:0] data_i,
  input  logic [NumReq-1:0][CW-1:0]           count_i,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic [N-1:0]                        out_data_o,
  output logic                                out_last_o,
  output logic [IW-1:0]                       out_id_o,
  output logic                                busy_o
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [IW-1:0] rr_ptr, winner, cand, id;
  logic [CW-1:0] pos, len, win_len;
  logic [Length-1:0][N-1:0] bank;
  logic found, last;
  always_comb begin
    found = 1'b0;
    winner = '0;
    cand = '0;
    for (int k = 0; k < NumReq; k++) begin
      cand = IW'((int'(rr_ptr) + k) % NumReq);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        winner = cand;
      end
    end
  end
  assign win_len = (count_i[winner] > CW'(Length)) ? CW'(Length) : count_i[winner];
  assign last = (pos == len - 1'b1);
  // Grant is combinational but must read as zero while reset is held
  assign gnt_o = (rst_ni && state == IDLE && found) ? {{(NumReq-1){1'b0}}, 1'b1} << winner : '0;
  assign busy_o = (state == SHIFT);
  assign out_valid_o = busy_o;
  assign out_data_o = busy_o ? bank[pos] : '0;
  assign out_last_o = busy_o && last;
  assign out_id_o = busy_o ? id : '0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      rr_ptr <= '0;
      pos <= '0;
      len <= '0;
      id <= '0;
      bank <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        bank <= data_i[winner];
        len <= win_len;
        id <= winner;
        pos <= '0;
        rr_ptr <= (int'(winner) == NumReq - 1) ? '0 : winner + 1'b1;
        state <= (win_len != '0) ? SHIFT : IDLE;
      end
    end else if (out_ready_i) begin
      pos <= last ? '0 : pos + 1'b1;
      state <= last ? IDLE : SHIFT;
    end
  end
endmodule

// File: tb/tb_p2s_stream_scheduler.sv
// tb_p2s_stream_scheduler: randomized and directed stimulus against a transaction-level
// round-robin model; expected beats are queued at grant time and popped on each handshake
module tb_p2s_stream_scheduler;
  localparam int N = 8, L = 3, NR = 4, CW = 2, IW = 2;
  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic [NR-1:0] req_i, gnt_o;
  logic [NR-1:0][L-1:0][N-1:0] data_i;
  logic [NR-1:0][CW-1:0] count_i;
  logic out_valid_o, out_ready_i, out_last_o, busy_o;
  logic [N-1:0] out_data_o;
  logic [IW-1:0] out_id_o;

  p2s_stream_scheduler #(.N(N), .Length(L), .NumReq(NR)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
    .data_i(data_i), .count_i(count_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_data_o(out_data_o), .out_last_o(out_last_o),
    .out_id_o(out_id_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {logic [N-1:0] d; logic l; logic [IW-1:0] id;} beat_t;
  beat_t q[$];
  int compared = 0, mismatched = 0, rr = 0, n;
  logic [NR-1:0] last_gnt = '0, eg;
  logic [IW-1:0] win, j;
  bit found, busy;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model and monitor: decide the expected grant from request levels and
  // the model pointer, and compare every presented beat against the queue head
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      check("reset_gnt", gnt_o, '0);
      check("reset_valid", out_valid_o, '0);
      q.delete();
      rr = 0;
      last_gnt = '0;
    end else begin
      busy = q.size() != 0;
      eg = '0;
      found = 0;
      win = '0;
      if (!busy)
        for (int k = 0; k < NR; k++) begin
          j = IW'((rr + k) % NR);
          if (!found && req_i[j]) begin
            found = 1;
            win = j;
          end
        end
      if (found) eg[win] = 1'b1;
      check("gnt", gnt_o, eg);
      check("valid", out_valid_o, busy);
      if (busy && out_valid_o) begin
        check("beat", {out_data_o, out_last_o, out_id_o}, q[0]);
        if (out_ready_i) void'(q.pop_front());
      end
      if (found) begin
        n = (count_i[win] > CW'(L)) ? L : int'(count_i[win]);
        for (int p = 0; p < n; p++)
          q.push_back(beat_t'{d: data_i[win][2'(p)], l: (p == n - 1), id: win});
        rr = (int'(win) + 1) % NR;
      end
      last_gnt = gnt_o;
    end
  end

  task automatic tick(int cycles, bit hold, logic [15:0] rpat);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk_i);
      #1;
      if (!hold) req_i = req_i & ~last_gnt;
      out_ready_i = rpat[i % 16];
    end
  endtask

  initial begin
    req_i = '0;
    data_i = '0;
    count_i = '0;
    out_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_outs", {out_data_o, out_last_o, out_id_o, busy_o}, '0);
    rst_ni = 1'b1;
    data_i[0] = {8'd33, 8'd22, 8'd11};
    count_i[0] = 2'd3;
    req_i = 4'b0001;
    tick(6, 0, 16'hFFFF);
    req_i = 4'b0001;
    tick(10, 0, 16'hFFE9);
    data_i = {$urandom, $urandom, $urandom};
    count_i = 8'h55;
    req_i = 4'b1111;
    tick(10, 1, 16'hFFFF);
    req_i = '0;
    tick(3, 0, 16'hFFFF);
    count_i[2] = 2'd0;
    req_i = 4'b0100;
    tick(2, 0, 16'hFFFF);
    count_i[1] = 2'd3;
    data_i[1] = {8'hA3, 8'hA2, 8'hA1};
    req_i = 4'b0010;
    tick(6, 0, 16'hFFFF);
    // Snapshot isolation: scramble the granted requester's inputs right after its grant
    data_i[0] = {8'h03, 8'h02, 8'h01};
    count_i[0] = 2'd3;
    req_i = 4'b0001;
    tick(1, 0, 16'hFFFF);
    data_i[0] = {8'hFF, 8'hEE, 8'hDD};
    count_i[0] = 2'd1;
    req_i[3] = 1'b1;
    tick(8, 0, 16'hFFFF);
    repeat (3000) begin
      @(posedge clk_i);
      #1;
      req_i = (req_i & ~last_gnt) | (4'($urandom) & 4'($urandom));
      data_i = {$urandom, $urandom, $urandom};
      count_i = 8'($urandom);
      out_ready_i = $urandom_range(0, 3) != 0;
    end
    req_i = '0;
    tick(12, 0, 16'hFFFF);
    data_i[0] = {8'h77, 8'h66, 8'h55};
    count_i[0] = 2'd3;
    req_i = 4'b0001;
    tick(3, 0, 16'hFFFF);
    rst_ni = 1'b0;
    #1;
    check("abort_valid", out_valid_o, '0);
    check("abort_last", out_last_o, '0);
    tick(2, 0, 16'hFFFF);
    rst_ni = 1'b1;
    count_i = 8'h55;
    req_i = 4'b0110;
    tick(8, 0, 16'hFFFF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
